// File: rtl/direction_voter.sv
// Sliding-window direction voter: keeps a histogram of the most recent WINDOW
// accepted direction bins, scans it for the most popular bin, and announces a
// new direction when that bin has enough votes and differs from the current one.
module direction_voter #(
   parameter int WINDOW    = 8,
   parameter int MIN_VOTES = 5
) (
   input  logic                    clk_in,
   input  logic                    rst_in,
   input  logic [3:0]              bin_in,
   input  logic                    bin_valid_in,
   input  logic                    clear_in,
   output logic                    ready_out,
   output logic [3:0]              dir_out,
   output logic [$clog2(WINDOW):0] votes_out,
   output logic                    confident_out,
   output logic                    dir_valid_out,
   input  logic                    dir_ready_in
);

   localparam int CW = $clog2(WINDOW) + 1;
   localparam int PW = $clog2(WINDOW);
   localparam logic [CW-1:0] FULL    = CW'(WINDOW);
   localparam logic [CW-1:0] MIN_CNT = CW'(MIN_VOTES);

   typedef enum logic [2:0] {IDLE, UPDATE, SCAN, DECIDE, OUTPUT} state_t;

   state_t        state;
   state_t        next_state;

   logic [CW-1:0] hist [16];
   logic [3:0]    history [WINDOW];
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] fill;
   logic [3:0]    new_bin;
   logic [3:0]    scan_idx;
   logic [CW-1:0] max_cnt;
   logic [3:0]    max_idx;

   logic          accept;
   logic          do_clear;
   logic          evict;
   logic [3:0]    evict_bin;
   logic          take;
   logic [15:0]   inc_vec;
   logic [15:0]   dec_vec;

   // Handshake qualifiers, eviction lookup, decision test and the per-bin
   // increment/decrement strobes used by the histogram update.
   always_comb begin
      do_clear  = (state == IDLE) && clear_in;
      accept    = (state == IDLE) && !clear_in && bin_valid_in;
      evict     = (fill == FULL);
      evict_bin = history[wr_ptr];
      take      = (max_cnt >= MIN_CNT) && (!confident_out || (max_idx != dir_out));
      inc_vec   = '0;
      dec_vec   = '0;
      for (int i = 0; i < 16; i++) begin
         inc_vec[i] = (new_bin == 4'(i));
         dec_vec[i] = evict && (evict_bin == 4'(i));
      end
   end

   // State register; reset abandons whatever scan or output is in flight.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) state <= IDLE;
      else         state <= next_state;
   end

   // Next-state decode and the handshake outputs that follow directly from state.
   always_comb begin
      next_state    = state;
      ready_out     = 1'b0;
      dir_valid_out = 1'b0;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (accept) next_state = UPDATE;
         end
         UPDATE: next_state = SCAN;
         SCAN: begin
            if (scan_idx == 4'd15) next_state = DECIDE;
         end
         DECIDE: begin
            if (take) next_state = OUTPUT;
            else      next_state = IDLE;
         end
         OUTPUT: begin
            dir_valid_out = 1'b1;
            if (dir_ready_in) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Histogram: a simultaneous evict and insert of the same bin cancels out,
   // so a counter never moves by more than one per update.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < 16; i++) hist[i] <= '0;
      end else if (do_clear) begin
         for (int i = 0; i < 16; i++) hist[i] <= '0;
      end else if (state == UPDATE) begin
         for (int i = 0; i < 16; i++) begin
            if (inc_vec[i] && !dec_vec[i])      hist[i] <= hist[i] + CW'(1);
            else if (dec_vec[i] && !inc_vec[i]) hist[i] <= hist[i] - CW'(1);
         end
      end
   end

   // History ring contents; an entry is only read for eviction once the ring is
   // full, by which time every slot has been written, so no reset is needed.
   always_ff @(posedge clk_in) begin
      if (state == UPDATE) history[wr_ptr] <= new_bin;
   end

   // Ring bookkeeping: write pointer wraps naturally (WINDOW is a power of two)
   // and fill saturates at WINDOW.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         wr_ptr <= '0;
         fill   <= '0;
      end else if (do_clear) begin
         wr_ptr <= '0;
         fill   <= '0;
      end else if (state == UPDATE) begin
         wr_ptr <= wr_ptr + PW'(1);
         if (fill != FULL) fill <= fill + CW'(1);
      end
   end

   // Capture the accepted bin so it stays stable through the update cycle.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in)     new_bin <= '0;
      else if (accept) new_bin <= bin_in;
   end

   // Linear scan of all 16 bins; strict greater-than keeps the lowest index on ties.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         scan_idx <= '0;
         max_cnt  <= '0;
         max_idx  <= '0;
      end else if (state == UPDATE) begin
         scan_idx <= '0;
         max_cnt  <= '0;
         max_idx  <= '0;
      end else if (state == SCAN) begin
         scan_idx <= scan_idx + 4'd1;
         if (hist[scan_idx] > max_cnt) begin
            max_cnt <= hist[scan_idx];
            max_idx <= scan_idx;
         end
      end
   end

   // Declared direction registers, only updated when a new winner is taken.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         dir_out       <= '0;
         votes_out     <= '0;
         confident_out <= 1'b0;
      end else if ((state == DECIDE) && take) begin
         dir_out       <= max_idx;
         votes_out     <= max_cnt;
         confident_out <= 1'b1;
      end
   end

endmodule

// File: tb/tb_direction_voter.sv
// Self-checking bench for direction_voter: directed vector table, hand-written
// backpressure/clear/reset sequences, and random bins against a queue model.
module tb_direction_voter;

   localparam int WINDOW    = 8;
   localparam int MIN_VOTES = 5;
   localparam int VW        = $clog2(WINDOW) + 1;
   localparam int LAT       = 19;

   logic          clk_in = 1'b0;
   logic          rst_in;
   logic [3:0]    bin_in;
   logic          bin_valid_in;
   logic          clear_in;
   logic          ready_out;
   logic [3:0]    dir_out;
   logic [VW-1:0] votes_out;
   logic          confident_out;
   logic          dir_valid_out;
   logic          dir_ready_in;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state: the last WINDOW accepted bins plus the declared direction.
   logic [3:0] hq [$];
   int         m_dir   = 0;
   int         m_votes = 0;
   logic       m_conf  = 1'b0;

   typedef struct {
      logic       clr;
      logic [3:0] bin;
      logic       exp_out;
      logic [3:0] exp_dir;
      logic [3:0] exp_votes;
   } vec_t;

   vec_t vecs [32];
   int   nv = 0;

   direction_voter #(.WINDOW(WINDOW), .MIN_VOTES(MIN_VOTES)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .bin_in        (bin_in),
      .bin_valid_in  (bin_valid_in),
      .clear_in      (clear_in),
      .ready_out     (ready_out),
      .dir_out       (dir_out),
      .votes_out     (votes_out),
      .confident_out (confident_out),
      .dir_valid_out (dir_valid_out),
      .dir_ready_in  (dir_ready_in)
   );

   always #5 clk_in = ~clk_in;

   // Hard stop in case something deadlocks outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic checkResetValues(input string pfx);
      checkOutput({pfx, "_ready"},     32'(ready_out),     1);
      checkOutput({pfx, "_valid"},     32'(dir_valid_out), 0);
      checkOutput({pfx, "_dir"},       32'(dir_out),       0);
      checkOutput({pfx, "_votes"},     32'(votes_out),     0);
      checkOutput({pfx, "_confident"}, 32'(confident_out), 0);
   endtask

   function automatic void addVec(input logic clr, input logic [3:0] b, input logic o,
                                  input logic [3:0] d, input logic [3:0] v);
      vecs[nv].clr       = clr;
      vecs[nv].bin       = b;
      vecs[nv].exp_out   = o;
      vecs[nv].exp_dir   = d;
      vecs[nv].exp_votes = v;
      nv++;
   endfunction

   function automatic void modelReset();
      hq.delete();
      m_dir   = 0;
      m_votes = 0;
      m_conf  = 1'b0;
   endfunction

   // Count every bin in the window, pick the lowest bin holding the largest
   // count, and declare it if it has enough votes and is a change of direction.
   function automatic void modelPush(input logic [3:0] b, output logic eg,
                                     output logic [3:0] ed, output logic [VW-1:0] ev);
      int cnt [16];
      int mx;
      int best;
      hq.push_back(b);
      if (hq.size() > WINDOW) void'(hq.pop_front());
      foreach (cnt[k]) cnt[k] = 0;
      foreach (hq[k]) cnt[hq[k]]++;
      mx = 0;
      foreach (cnt[k]) if (cnt[k] > mx) mx = cnt[k];
      best = 0;
      while (cnt[best] != mx) best++;
      eg = (mx >= MIN_VOTES) && (!m_conf || best != m_dir);
      if (eg) begin
         m_dir   = best;
         m_votes = mx;
         m_conf  = 1'b1;
      end
      ed = 4'(m_dir);
      ev = VW'(m_votes);
   endfunction

   // Offer one bin and follow it to either an output or a return to IDLE.
   // lat counts rising edges with the accepting edge as 1.
   task automatic applyStimulus(input logic [3:0] b, output logic got, output logic [3:0] d,
                                output logic [VW-1:0] v, output logic c, output int lat);
      int guard;
      got   = 1'b0;
      d     = '0;
      v     = '0;
      c     = 1'b0;
      lat   = 0;
      guard = 0;
      @(negedge clk_in);
      while (!ready_out && guard < 100) begin
         @(negedge clk_in);
         guard++;
      end
      if (!ready_out) begin
         checkOutput("ready_timeout", 32'(ready_out), 1);
         return;
      end
      bin_in       = b;
      bin_valid_in = 1'b1;
      @(posedge clk_in);
      lat = 1;
      @(negedge clk_in);
      bin_valid_in = 1'b0;
      bin_in       = 4'($urandom_range(0, 15));
      while (!dir_valid_out && !ready_out && lat < 100) begin
         @(posedge clk_in);
         lat++;
         @(negedge clk_in);
      end
      if (dir_valid_out) begin
         got = 1'b1;
         d   = dir_out;
         v   = votes_out;
         c   = confident_out;
         if (dir_ready_in) begin
            @(posedge clk_in);
            @(negedge clk_in);
            checkOutput("valid_drop", 32'(dir_valid_out), 0);
         end
      end
   endtask

   task automatic sendAndCheck(input logic [3:0] b);
      logic          eg;
      logic [3:0]    ed;
      logic [VW-1:0] ev;
      logic          got;
      logic          c;
      logic [3:0]    d;
      logic [VW-1:0] v;
      int            lat;
      modelPush(b, eg, ed, ev);
      applyStimulus(b, got, d, v, c, lat);
      checkOutput("out_flag", 32'(got), 32'(eg));
      checkOutput("latency", 32'(lat), LAT);
      if (eg && got) begin
         checkOutput("dir", 32'(d), 32'(ed));
         checkOutput("votes", 32'(v), 32'(ev));
         checkOutput("confident", 32'(c), 1);
      end
   endtask

   // Clear with a bin offered in the same cycle: clear must win and no bin is taken.
   task automatic pulseClear();
      int guard;
      guard = 0;
      @(negedge clk_in);
      while (!ready_out && guard < 100) begin
         @(negedge clk_in);
         guard++;
      end
      clear_in     = 1'b1;
      bin_valid_in = 1'b1;
      bin_in       = 4'($urandom_range(0, 15));
      @(posedge clk_in);
      @(negedge clk_in);
      clear_in     = 1'b0;
      bin_valid_in = 1'b0;
      checkOutput("clear_stays_idle", 32'(ready_out), 1);
      checkOutput("clear_keeps_dir", 32'(dir_out), 32'(m_dir));
      hq.delete();
   endtask

   initial begin
      logic          eg;
      logic [3:0]    ed;
      logic [VW-1:0] ev;
      logic          got;
      logic          c;
      logic [3:0]    d;
      logic [VW-1:0] v;
      int            lat;
      int            r;
      logic          seen;

      rst_in       = 1'b0;
      bin_in       = '0;
      bin_valid_in = 1'b0;
      clear_in     = 1'b0;
      dir_ready_in = 1'b1;

      // Power-on reset and release.
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      checkResetValues("in_reset");
      rst_in = 1'b1;
      @(negedge clk_in);
      checkResetValues("after_reset");

      // Build-up, eviction with tie, then clear followed by a repeated winner.
      for (int i = 0; i < 4; i++) addVec(1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
      addVec(1'b0, 4'd3, 1'b1, 4'd3, 4'd5);
      for (int i = 0; i < 3; i++) addVec(1'b0, 4'd3, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 4; i++) addVec(1'b0, 4'd9, 1'b0, 4'd0, 4'd0);
      addVec(1'b0, 4'd9, 1'b1, 4'd9, 4'd5);
      addVec(1'b1, 4'd0, 1'b0, 4'd0, 4'd0);
      for (int i = 0; i < 5; i++) addVec(1'b0, 4'd9, 1'b0, 4'd0, 4'd0);

      for (int i = 0; i < nv; i++) begin
         if (vecs[i].clr) begin
            pulseClear();
         end else begin
            modelPush(vecs[i].bin, eg, ed, ev);
            applyStimulus(vecs[i].bin, got, d, v, c, lat);
            checkOutput($sformatf("tbl%0d_out", i), 32'(got), 32'(vecs[i].exp_out));
            checkOutput($sformatf("tbl%0d_lat", i), 32'(lat), LAT);
            if (vecs[i].exp_out) begin
               checkOutput($sformatf("tbl%0d_dir", i), 32'(d), 32'(vecs[i].exp_dir));
               checkOutput($sformatf("tbl%0d_votes", i), 32'(v), 32'(vecs[i].exp_votes));
               checkOutput($sformatf("tbl%0d_conf", i), 32'(c), 1);
            end
         end
      end

      // Backpressure: hold the presented direction while bins are offered.
      pulseClear();
      for (int i = 0; i < 4; i++) sendAndCheck(4'd7);
      dir_ready_in = 1'b0;
      modelPush(4'd7, eg, ed, ev);
      applyStimulus(4'd7, got, d, v, c, lat);
      checkOutput("bp_out", 32'(got), 1);
      checkOutput("bp_first_dir", 32'(d), 7);
      for (int k = 0; k < 10; k++) begin
         bin_valid_in = k[0];
         bin_in       = 4'd1;
         @(posedge clk_in);
         @(negedge clk_in);
         checkOutput($sformatf("bp%0d_valid", k), 32'(dir_valid_out), 1);
         checkOutput($sformatf("bp%0d_dir", k), 32'(dir_out), 7);
         checkOutput($sformatf("bp%0d_votes", k), 32'(votes_out), 5);
         checkOutput($sformatf("bp%0d_ready", k), 32'(ready_out), 0);
      end
      bin_valid_in = 1'b0;
      dir_ready_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("bp_release_valid", 32'(dir_valid_out), 0);
      checkOutput("bp_release_ready", 32'(ready_out), 1);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (dir_valid_out || !ready_out) seen = 1'b1;
      end
      checkOutput("bp_single_handshake", 32'(seen), 0);

      // Reset eight cycles into SCAN: everything snaps back, the bin is forgotten.
      @(negedge clk_in);
      bin_in       = 4'd2;
      bin_valid_in = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      bin_valid_in = 1'b0;
      repeat (9) @(posedge clk_in);
      @(negedge clk_in);
      checkOutput("scan_busy", 32'(ready_out), 0);
      rst_in = 1'b0;
      #1;
      checkResetValues("rst_scan");
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      modelReset();
      for (int i = 0; i < 4; i++) sendAndCheck(4'd2);

      // Reset while a direction is being presented: it must not reappear.
      dir_ready_in = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 8 && !got; i++) begin
         modelPush(4'd3, eg, ed, ev);
         applyStimulus(4'd3, got, d, v, c, lat);
         checkOutput("pre_rst_flag", 32'(got), 32'(eg));
      end
      checkOutput("pre_rst_out", 32'(got), 1);
      checkOutput("pre_rst_dir", 32'(d), 3);
      rst_in = 1'b0;
      #1;
      checkResetValues("rst_output");
      @(negedge clk_in);
      rst_in       = 1'b1;
      dir_ready_in = 1'b1;
      modelReset();
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (dir_valid_out) seen = 1'b1;
      end
      checkOutput("rst_output_discarded", 32'(seen), 0);

      // Random bins, skewed toward a few directions so decisions happen often.
      for (int it = 0; it < 200; it++) begin
         r = $urandom_range(0, 15);
         if (r == 0)      pulseClear();
         else if (r < 12) sendAndCheck(4'($urandom_range(0, 3)));
         else             sendAndCheck(4'($urandom_range(0, 15)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
